// File: rtl/seg_msg_scroller.sv
// 7-segment message scroller: debounced manual stepping or prescaled auto scrolling with pause.
// Latency: seg registered one edge behind idx; button press reaches idx DEBOUNCE_CYCLES+2 edges after btn rises.
// Backpressure: none; free-running display path, every step is taken on the edge it occurs.
module seg_msg_scroller #(
    parameter int MSG_LEN         = 14,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int AUTO_PERIOD     = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       mode_auto,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [7:0] seg,
    output logic [3:0] idx,
    output logic       paused,
    output logic       wrap
);
    localparam int              DB_W        = $clog2(DEBOUNCE_CYCLES);
    localparam int              PS_W        = $clog2(AUTO_PERIOD);
    localparam logic [3:0]      LAST_IDX    = 4'(MSG_LEN - 1);
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     PERIOD_FULL = 32'(AUTO_PERIOD);

    typedef enum logic [1:0] {MANUAL, AUTO_RUN, AUTO_PAUSED} state_t;

    state_t          state, state_nxt;
    logic            btn_m, btn_s, db, db_d, press;
    logic [DB_W-1:0] db_cnt;
    logic            mode_q, mode_chg;
    logic [PS_W-1:0] ps, ps_nxt, ps_lim;
    logic            step, step_wrap;
    logic [3:0]      idx_nxt;

    function automatic logic [7:0] rom_lookup(input logic [3:0] a);
        case (a)
            4'd0:    rom_lookup = 8'h80;
            4'd1:    rom_lookup = 8'h5B;
            4'd2:    rom_lookup = 8'h4F;
            4'd3:    rom_lookup = 8'h15;
            4'd4:    rom_lookup = 8'h7E;
            4'd5:    rom_lookup = 8'h0E;
            4'd6:    rom_lookup = 8'h5F;
            4'd7:    rom_lookup = 8'h3E;
            4'd8:    rom_lookup = 8'h0E;
            4'd9:    rom_lookup = 8'h5F;
            4'd10:   rom_lookup = 8'h7E;
            4'd11:   rom_lookup = 8'h15;
            4'd12:   rom_lookup = 8'h3E;
            4'd13:   rom_lookup = 8'h0E;
            default: rom_lookup = 8'h00;
        endcase
    endfunction

    // Synchroniser plus debounce: db only follows btn_s after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            db     <= 1'b0;
            db_d   <= 1'b0;
            db_cnt <= '0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            db_d  <= db;
            if (btn_s == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press    = db & ~db_d;
    assign mode_chg = mode_auto != mode_q;
    assign ps_lim   = PS_W'((PERIOD_FULL >> speed) - 32'd1);
    assign paused   = (state == AUTO_PAUSED);

    always_comb begin
        state_nxt = state;
        ps_nxt    = ps;
        step      = 1'b0;
        if (mode_chg) begin
            // A mode flip swallows any coincident press
            state_nxt = mode_auto ? AUTO_RUN : MANUAL;
            ps_nxt    = '0;
        end else begin
            case (state)
                MANUAL: begin
                    ps_nxt = '0;
                    step   = press;
                end
                AUTO_RUN: begin
                    if (ps > ps_lim) begin
                        ps_nxt = '0;
                    end else if (ps == ps_lim) begin
                        ps_nxt = '0;
                        step   = 1'b1;
                    end else begin
                        ps_nxt = ps + PS_W'(1);
                    end
                    if (press) state_nxt = AUTO_PAUSED;
                end
                AUTO_PAUSED: begin
                    if (press) state_nxt = AUTO_RUN;
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

    always_comb begin
        if (dir) begin
            step_wrap = (idx == 4'd0);
            idx_nxt   = step_wrap ? LAST_IDX : idx - 4'd1;
        end else begin
            step_wrap = (idx == LAST_IDX);
            idx_nxt   = step_wrap ? 4'd0 : idx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MANUAL;
            ps     <= '0;
            mode_q <= 1'b0;
            idx    <= 4'd0;
            wrap   <= 1'b0;
            seg    <= 8'h00;
        end else begin
            state  <= state_nxt;
            ps     <= ps_nxt;
            mode_q <= mode_auto;
            wrap   <= step & step_wrap;
            seg    <= rom_lookup(idx);
            if (step) idx <= idx_nxt;
        end
    end
endmodule

// File: doc/seg_msg_scroller.md
# seg_msg_scroller

Parametrised 7-segment message scroller, the next generation of the top-level single-step name display. It steps through a fixed 16-entry segment ROM from a debounced push-button (manual mode) or a free-running prescaled tick (auto mode), with selectable direction, four auto speeds, and pause/resume. It sits between the pad inputs and `uo_out` of the tile top, which maps `seg` directly to the display pins.

## Interface
- `MSG_LEN`, 14: active message length; legal range 2..16; `idx` wraps within 0..MSG_LEN-1.
- `DEBOUNCE_CYCLES`, 65536: consecutive clk cycles a synchronised button level must differ from the accepted level before it is accepted; legal range ≥2.
- `AUTO_PERIOD`, 4194304: auto-step period in clk cycles at `speed`=0; legal range ≥16.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `btn`  in  1  raw, asynchronous, bouncy push-button; active-high.
- `mode_auto`  in  1  0 = manual stepping, 1 = auto scrolling.
- `dir`  in  1  0 = forward (idx+1), 1 = reverse (idx-1); sampled on each step.
- `speed`  in  2  auto period = AUTO_PERIOD >> speed (floor).
- `seg`  out  8  registered segment pattern; bit7 = dp, bits6:0 = a..g.
- `idx`  out  4  current message index.
- `paused`  out  1  high in AUTO_PAUSED.
- `wrap`  out  1  one-cycle pulse on the step that wraps idx.

## Operation
- ROM, index 0..13: 0x80, 0x5B, 0x4F, 0x15, 0x7E, 0x0E, 0x5F, 0x3E, 0x0E, 0x5F, 0x7E, 0x15, 0x3E, 0x0E; indices 14, 15 = 0x00.
- Button path: 2-flop synchroniser → `btn_s`. Debounce counter increments each cycle `btn_s` ≠ accepted level `db`, clears when equal. When it would reach DEBOUNCE_CYCLES, `db` ← `btn_s` and counter clears. `press` = `db` & ~`db_d` (one cycle, rising only). Releases produce no event.
- State machine: MANUAL, AUTO_RUN, AUTO_PAUSED.
  - MANUAL: `press` performs one step. Prescaler held at 0.
  - AUTO_RUN: prescaler counts 0..(AUTO_PERIOD>>speed)-1. On the edge where it equals its limit, it clears and one step occurs. `press` → AUTO_PAUSED.
  - AUTO_PAUSED: prescaler frozen at its current value, no steps. `press` → AUTO_RUN; counting resumes from the frozen value.
- Mode change: a registered copy of `mode_auto` is kept. On any edge where `mode_auto` differs from that copy:
  - state ← AUTO_RUN if `mode_auto`=1, else MANUAL;
  - prescaler ← 0;
  - any `press` in that cycle is ignored.
- Step:
  - Forward: idx ← (idx == MSG_LEN-1) ? 0 : idx+1.
  - Reverse: idx ← (idx == 0) ? MSG_LEN-1 : idx-1.
  - `wrap` is high for the cycle after a wrapping step.
- Tick and `press` on the same edge in AUTO_RUN: the step occurs and state → AUTO_PAUSED.
- `speed` change mid-count: if prescaler > new limit, it clears to 0 on the next edge with no step.
- `seg` ← ROM[idx] every cycle, so `seg` lags `idx` by one edge.

## Timing
- Reset values: idx=0, seg=0x00, wrap=0, paused=0, state=MANUAL, db=0, sync flops=0, prescaler=0, debounce counter=0, registered mode=0.
- First edge after reset deassertion: seg=0x80.
- `rst` mid-operation overrides all events on that edge, including an in-flight debounce or a pending tick.
- Button latency, taking edge 0 as the first edge sampling `btn`=1 with `btn` held stable:
  - `db` rises at edge 1+DEBOUNCE_CYCLES;
  - idx updates at edge 2+DEBOUNCE_CYCLES;
  - seg updates at edge 3+DEBOUNCE_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES cycles produces no event.
- Auto: steps are exactly AUTO_PERIOD>>speed cycles apart. The first step comes (AUTO_PERIOD>>speed) edges after entering AUTO_RUN from a mode change.
- `paused` and state changes are visible the edge after `press`.

## Test plan
- Reset/manual, DEBOUNCE_CYCLES=4: release rst, then hold btn=1 from edge 0. Required: seg=0x80 after first edge; idx=1 at edge 6; seg=0x5B at edge 7.
- Bounce rejection, DEBOUNCE_CYCLES=4: toggle btn every 2 cycles for 40 cycles, then hold 0. Required: idx stays 0, no `wrap`.
- Forward/reverse wrap, MSG_LEN=14: 14 manual presses with dir=0 → idx 13→0, wrap pulses once, seg=0x80. Then dir=1 and one press → idx=13, wrap pulses, seg=0x0E.
- Auto speeds, AUTO_PERIOD=64: mode_auto=1, speed=0 → steps 64 cycles apart. speed=3 → steps 8 cycles apart. MSG_LEN=5 forward → idx 0,1,2,3,4,0 with wrap on the 4→0 step.
- Pause/resume, AUTO_PERIOD=64: press at prescaler=20 → paused=1, idx frozen for 200 cycles. Press again → next step 44 cycles after resume. Press coincident with a tick → idx advances once and paused=1.
- Mode switch mid-count: mode_auto 1→0 at prescaler=30 → state MANUAL and no further auto steps. 0→1 → first step exactly AUTO_PERIOD cycles later. Assert rst mid-debounce → all outputs return to reset values next edge.
